// File: rtl/wb_pkg.sv
// Shared types and constants for the ALU writeback stage.
// Entry layout is fixed by WB_WIDTH/WB_REGS; the top-level parameters must match them.
package wb_pkg;
  localparam int WB_WIDTH = 16;
  localparam int WB_REGS  = 8;
  localparam int WB_RA    = $clog2(WB_REGS);

  localparam logic [2:0] CC_RESET = 3'b010;
  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  typedef struct packed {
    logic                write;
    logic                set_cc;
    logic [WB_RA-1:0]    dst;
    logic [WB_WIDTH-1:0] result;
    logic [2:0]          cc;
  } wb_entry_t;

  function automatic logic cc_is_onehot(input logic [2:0] cc);
    return (cc == 3'b100) || (cc == 3'b010) || (cc == 3'b001);
  endfunction
endpackage

// File: rtl/wb_queue.sv
// DEPTH-entry circular buffer of writeback entries. Callers gate push/pop legality;
// flush wins over both. All entries and the valid mask are exposed for forwarding.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  wb_entry_t        din_i,
  output wb_entry_t        head_o,
  output wb_entry_t        entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PW-1:0]    rptr_o,
  output logic [CW-1:0]    count_o
);
  wb_entry_t        ent_q [DEPTH];
  wb_entry_t        ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      // Dropping everything: read pointer catches up to write pointer.
      vld_d   = '0;
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (push_i) begin
        ent_d[wptr_q] = din_i;
        vld_d[wptr_q] = 1'b1;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop_i) begin
        vld_d[rptr_q] = 1'b0;
        rptr_d        = rptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_o    = ent_q[rptr_q];
  assign entries_o = ent_q;
  assign valid_o   = vld_q;
  assign rptr_o    = rptr_q;
  assign count_o   = count_q;
endmodule

// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: queues results, retires one per cycle into the
// register-file port and CC register, and forwards pending results to issue.
module alu_writeback
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int REGS  = WB_REGS,
  parameter int DEPTH = 2,
  localparam int RA = $clog2(REGS),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_write,
  input  logic             in_set_cc,
  input  logic [RA-1:0]    in_dst,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_cc,
  input  logic             flush,
  input  logic             wb_stall,
  output logic             wb_en,
  output logic [RA-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [2:0]       cc_q,
  input  logic [RA-1:0]    fwd_addr,
  output logic             fwd_hit,
  output logic [WIDTH-1:0] fwd_data,
  output logic [CW-1:0]    count
);
  logic             push, pop;
  wb_entry_t        din, head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    rptr, idx;
  logic [2:0]       cc_d;

  // in_ready depends only on registered occupancy, so a full queue never passes through.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count != '0) && !wb_stall && !flush;
  assign din      = '{write: in_write, set_cc: in_set_cc, dst: in_dst,
                      result: in_result, cc: in_cc};

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (flush),
    .din_i    (din),
    .head_o   (head),
    .entries_o(entries),
    .valid_o  (valid),
    .rptr_o   (rptr),
    .count_o  (count)
  );

  assign wb_en   = pop && head.write;
  assign wb_addr = wb_en ? head.dst : '0;
  assign wb_data = wb_en ? head.result : '0;

  assign cc_d = (pop && head.set_cc) ? head.cc : cc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cc_q <= CC_RESET;
    else     cc_q <= cc_d;
  end

  // Walk oldest to youngest from the read pointer so the last match is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (valid[idx] && entries[idx].write && entries[idx].dst == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].result;
      end
    end
  end

  a_cc_onehot: assert property (@(posedge clk) disable iff (rst)
    (push && in_set_cc) |-> cc_is_onehot(in_cc));
endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a scoreboard of expected register writes is
// drained by a monitor on every wb_en, alongside directed state checks.
module tb_alu_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_write, in_set_cc;
  logic [2:0]  in_dst;
  logic [15:0] in_result;
  logic [2:0]  in_cc;
  logic        flush, wb_stall, wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  cc_q;
  logic [2:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [1:0]  count;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb [$];
  int  checks = 0;
  int  passes = 0;

  alu_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write),
    .in_set_cc(in_set_cc), .in_dst(in_dst), .in_result(in_result), .in_cc(in_cc),
    .flush(flush), .wb_stall(wb_stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .cc_q(cc_q),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic sc, input logic [2:0] d,
                       input logic [15:0] r, input logic [2:0] c);
    in_valid = v; in_write = w; in_set_cc = sc; in_dst = d; in_result = r; in_cc = c;
  endtask

  task automatic expect_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every register write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL wb_unexpected: got addr=%0h data=%0h expected no write", wb_addr, wb_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wb_addr === e.addr && wb_data === e.data) passes++;
        else $display("FAIL wb_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                      wb_addr, wb_data, e.addr, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wb_stall = 1'b0; fwd_addr = 3'd0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 3'b000);
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cc", cc_q, 3'b010);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fwd_hit", fwd_hit, 0);

    // Single push, one-cycle latency, CC update on pop
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'd3, 16'h00A5, 3'b001);
    expect_wr(3'd3, 16'h00A5);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_count", count, 1);
    chk("t2_wb_en", wb_en, 1);
    tick();
    @(negedge clk);
    chk("t2_cc", cc_q, 3'b001);
    chk("t2_count_after", count, 0);

    // Fill under stall; youngest forwarding match
    tick();
    wb_stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h1111, 3'b001);
    expect_wr(3'd1, 16'h1111);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h2222, 3'b001);
    expect_wr(3'd1, 16'h2222);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd5, 16'h3333, 3'b001);
    fwd_addr = 3'd1;
    @(negedge clk);
    chk("t3_count", count, 2);
    chk("t3_ready", in_ready, 0);
    chk("t3_fwd_hit", fwd_hit, 1);
    chk("t3_fwd_data", fwd_data, 16'h2222);
    chk("t3_wb_en", wb_en, 0);

    // Release stall from full with in_valid held: pop first, push next cycle
    tick();
    wb_stall = 1'b0;
    @(negedge clk);
    chk("t4_count_full", count, 2);
    chk("t4_ready_full", in_ready, 0);
    chk("t4_fwd_head_hit", fwd_hit, 1);
    chk("t4_fwd_head_data", fwd_data, 16'h2222);
    tick();
    wb_stall = 1'b1;
    @(negedge clk);
    chk("t4_count_1", count, 1);
    chk("t4_ready_1", in_ready, 1);
    expect_wr(3'd5, 16'h3333);
    tick();
    in_valid = 1'b0;
    fwd_addr = 3'd5;
    @(negedge clk);
    chk("t4_count_2", count, 2);
    chk("t4_fwd5_hit", fwd_hit, 1);
    chk("t4_fwd5_data", fwd_data, 16'h3333);
    tick();
    wb_stall = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t4_drained", count, 0);
    chk("t4_sb_empty", sb.size(), 0);

    // Compare-only entry sets CC silently; write-only entry leaves CC alone
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'd2, 16'h7777, 3'b100);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_silent_wb_en", wb_en, 0);
    tick();
    @(negedge clk);
    chk("t5_cc_set", cc_q, 3'b100);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd4, 16'h4444, 3'b001);
    expect_wr(3'd4, 16'h4444);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_wb_en", wb_en, 1);
    tick();
    @(negedge clk);
    chk("t5_cc_hold", cc_q, 3'b100);
    chk("t5_count", count, 0);

    // Flush with two pending and a same-cycle push
    tick();
    wb_stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'd6, 16'h6666, 3'b001);
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'd7, 16'h7777, 3'b001);
    tick();
    flush = 1'b1;
    wb_stall = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 3'd0, 16'hDEAD, 3'b001);
    @(negedge clk);
    chk("t6_flush_wb_en", wb_en, 0);
    chk("t6_flush_wb_data", wb_data, 0);
    chk("t6_pre_count", count, 2);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    fwd_addr = 3'd6;
    @(negedge clk);
    chk("t6_count", count, 0);
    chk("t6_fwd_hit", fwd_hit, 0);
    chk("t6_fwd_data", fwd_data, 0);
    chk("t6_cc", cc_q, 3'b100);
    chk("t6_ready", in_ready, 1);
    fwd_addr = 3'd0;
    #1;
    chk("t6_fwd_dropped", fwd_hit, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("t6_count_idle", count, 0);
    chk("end_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
